// File: rtl/tb_clint_ctrl.sv
// Core-local interruptor: shared 64-bit mtime, per-core mtimecmp/msip, and a
// single-outstanding valid/ready register port that drives msip/mtip per hart.
module tb_clint_ctrl #(
    parameter int unsigned NrCores = 9,
    parameter int unsigned TickDiv = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [15:0]        req_addr_i,
    input  logic               req_write_i,
    input  logic [31:0]        req_wdata_i,
    input  logic [3:0]         req_strb_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [31:0]        rsp_rdata_o,
    output logic               rsp_error_o,
    output logic [NrCores-1:0] msip_o,
    output logic [NrCores-1:0] mtip_o
);

    localparam int unsigned IdxW = (NrCores > 1) ? $clog2(NrCores) : 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t             state;
    logic [63:0]        mtime;
    logic [15:0]        presc;
    logic [NrCores-1:0] msip;
    logic [63:0]        mtimecmp [NrCores];
    logic [NrCores-1:0] mtip;

    logic               is_msip;
    logic               is_cmp;
    logic               is_time;
    logic               hi;
    logic               dec_err;
    logic [12:0]        full_idx;
    logic [IdxW-1:0]    core;
    logic [31:0]        rval;
    logic               accept;
    logic               wr;
    logic               tick;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    // Address decode; full_idx keeps all upper bits so out-of-range cores are caught
    always_comb begin
        is_msip  = 1'b0;
        is_cmp   = 1'b0;
        is_time  = 1'b0;
        full_idx = '0;
        if (req_addr_i < 16'h4000) begin
            is_msip  = 1'b1;
            full_idx = {1'b0, req_addr_i[13:2]};
        end else if (req_addr_i < 16'hBFF8) begin
            is_cmp   = 1'b1;
            full_idx = req_addr_i[15:3] - 13'h0800;
        end else if (req_addr_i[15:3] == 13'h17FF) begin
            is_time  = 1'b1;
        end
        hi      = req_addr_i[2];
        core    = full_idx[IdxW-1:0];
        dec_err = (req_addr_i[1:0] != 2'b00) || !(is_msip || is_cmp || is_time) ||
                  ((is_msip || is_cmp) && (full_idx >= 13'(NrCores)));
    end

    always_comb begin
        rval = '0;
        if (!dec_err) begin
            if (is_msip)     rval = {31'b0, msip[core]};
            else if (is_cmp) rval = hi ? mtimecmp[core][63:32] : mtimecmp[core][31:0];
            else             rval = hi ? mtime[63:32] : mtime[31:0];
        end
    end

    assign accept = (state == IDLE) && req_valid_i;
    assign wr     = accept && req_write_i && !dec_err;
    assign tick   = (presc == 16'(TickDiv - 1));

    // A same-cycle mtime write suppresses the increment; the prescaler runs on regardless
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime <= '0;
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;
            if (wr && is_time) begin
                if (hi) mtime[63:32] <= merge(mtime[63:32], req_wdata_i, req_strb_i);
                else    mtime[31:0]  <= merge(mtime[31:0], req_wdata_i, req_strb_i);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            msip <= '0;
            for (int unsigned i = 0; i < NrCores; i++) mtimecmp[i] <= '1;
        end else if (wr && is_msip) begin
            if (req_strb_i[0]) msip[core] <= req_wdata_i[0];
        end else if (wr && is_cmp) begin
            if (hi) mtimecmp[core][63:32] <= merge(mtimecmp[core][63:32], req_wdata_i, req_strb_i);
            else    mtimecmp[core][31:0]  <= merge(mtimecmp[core][31:0], req_wdata_i, req_strb_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtip <= '0;
        end else begin
            for (int unsigned i = 0; i < NrCores; i++) mtip[i] <= (mtime >= mtimecmp[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    state       <= RESP;
                    req_ready_o <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= req_write_i ? '0 : rval;
                    rsp_error_o <= dec_err;
                end
                RESP: if (rsp_ready_i) begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                    rsp_rdata_o <= '0;
                    rsp_error_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign msip_o = msip;
    assign mtip_o = mtip;

endmodule
